mdio_responder: RTL and testbench



---
 rtl/mdio_responder.sv | 200 ++++++++++++++++++++
 tb/tb_mdio_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames for PHY_ADDR, serves registers via strobes.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to accept a 1-bit preamble after any completed frame.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         MIN_PREAMBLE = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_enable,
  output logic        reg_rd_strobe,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr_strobe,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata
);

  localparam int            CW      = $clog2(MIN_PREAMBLE + 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(MIN_PREAMBLE);

  typedef enum logic [2:0] {HUNT, HEADER, SKIP, READ, WRITE} state_t;

  logic mdc_meta, mdc_s, mdc_d;
  logic mdio_meta, mdio_s;
  logic rise, bit_in;

  // Synchronizers reset to the idle-high level so reset release never fakes an MDC rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {mdc_meta, mdc_s, mdc_d} <= 3'b111;
      {mdio_meta, mdio_s}      <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge value, so the chain shifts one stage per clk.
      mdc_meta  <= mdc;
      mdc_s     <= mdc_meta;
      mdc_d     <= mdc_s;
      mdio_meta <= mdio_in;
      mdio_s    <= mdio_meta;
    end
  end

  assign rise   = mdc_s & ~mdc_d;
  assign bit_in = mdio_s;

  state_t        state, state_n;
  logic [4:0]    bit_idx, bit_idx_n;
  logic [CW-1:0] pre_cnt, pre_cnt_n;
  logic [16:0]   sh, sh_n;
  logic          is_read, is_read_n;
  logic [4:0]    regad, regad_n;
  logic [15:0]   rd_sh, rd_sh_n;
  logic          mdio_out_n, mdio_enable_n, rd_strobe_n, wr_strobe_n;
  logic [4:0]    reg_addr_n;
  logic [15:0]   reg_wdata_n;
  logic          frame_end;
  logic          st_ok;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic sup_ok, sup_ok_n;
  assign st_ok = (pre_cnt == PRE_MAX) || (sup_ok && (pre_cnt != '0));
`else
  assign st_ok = (pre_cnt == PRE_MAX);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      bit_idx       <= '0;
      pre_cnt       <= '0;
      sh            <= '0;
      is_read       <= 1'b0;
      regad         <= '0;
      rd_sh         <= '0;
      mdio_out      <= 1'b1;
      mdio_enable   <= 1'b0;
      reg_rd_strobe <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      sup_ok        <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      bit_idx       <= bit_idx_n;
      pre_cnt       <= pre_cnt_n;
      sh            <= sh_n;
      is_read       <= is_read_n;
      regad         <= regad_n;
      rd_sh         <= rd_sh_n;
      mdio_out      <= mdio_out_n;
      mdio_enable   <= mdio_enable_n;
      reg_rd_strobe <= rd_strobe_n;
      reg_wr_strobe <= wr_strobe_n;
      reg_addr      <= reg_addr_n;
      reg_wdata     <= reg_wdata_n;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      sup_ok        <= sup_ok_n;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_n       = state;
    bit_idx_n     = bit_idx;
    pre_cnt_n     = pre_cnt;
    sh_n          = sh;
    is_read_n     = is_read;
    regad_n       = regad;
    rd_sh_n       = rd_sh;
    mdio_out_n    = mdio_out;
    mdio_enable_n = mdio_enable;
    rd_strobe_n   = 1'b0;
    wr_strobe_n   = 1'b0;
    reg_addr_n    = reg_addr;
    reg_wdata_n   = reg_wdata;
    frame_end     = 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    sup_ok_n      = sup_ok;
`endif

    if (rise) begin
      sh_n      = {sh[15:0], bit_in};
      bit_idx_n = bit_idx + 5'd1;
      unique case (state)
        HUNT: begin
          bit_idx_n = 5'd1;
          if (bit_in) begin
            if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + CW'(1);
          end else begin
            if (st_ok) state_n = HEADER;
            pre_cnt_n = '0;
          end
        end
        HEADER: begin
          // sh[0] is the previous bit; header fields are checked as soon as they are complete.
          case (bit_idx)
            5'd1:  if (!bit_in) state_n = HUNT;
            5'd3: begin
              if ({sh[0], bit_in} == 2'b10)      is_read_n = 1'b1;
              else if ({sh[0], bit_in} == 2'b01) is_read_n = 1'b0;
              else                               state_n   = HUNT;
            end
            5'd8:  if ({sh[3:0], bit_in} != PHY_ADDR) state_n = SKIP;
            5'd13: begin
              regad_n = {sh[3:0], bit_in};
              if (is_read) begin
                state_n     = READ;
                reg_addr_n  = {sh[3:0], bit_in};
                rd_strobe_n = 1'b1;
              end else begin
                state_n = WRITE;
              end
            end
            default: ;
          endcase
        end
        SKIP: if (bit_idx == 5'd31) frame_end = 1'b1;
        READ: begin
          // Each rise drives the value the master samples on the following rise.
          if (bit_idx == 5'd14) begin
            rd_sh_n       = reg_rdata;
            mdio_enable_n = 1'b1;
            mdio_out_n    = 1'b0;
          end else if (bit_idx == 5'd31) begin
            mdio_enable_n = 1'b0;
            mdio_out_n    = 1'b1;
            frame_end     = 1'b1;
          end else begin
            mdio_out_n = rd_sh[15];
            rd_sh_n    = {rd_sh[14:0], 1'b0};
          end
        end
        WRITE: begin
          if (bit_idx == 5'd31) begin
            if (sh[16:15] == 2'b10) begin
              reg_addr_n  = regad;
              reg_wdata_n = {sh[14:0], bit_in};
              wr_strobe_n = 1'b1;
            end
            frame_end = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase

      if (frame_end) begin
        state_n   = HUNT;
        pre_cnt_n = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        sup_ok_n  = 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: a master task drives directed MDIO frames, a monitor checks strobes and read data.
`timescale 1ns/1ps
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic [15:0] reg_rdata = 16'h0000;
  logic        mdio_out, mdio_enable, reg_rd_strobe, reg_wr_strobe;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;

  int checks = 0;
  int errors = 0;

  typedef enum {EV_WR, EV_RD, EV_RDATA} kind_e;
  typedef struct {
    kind_e       kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rdata_obs;
  event        rdata_ev;

  mdio_responder #(.PHY_ADDR(5'd1), .MIN_PREAMBLE(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mdc          (mdc),
    .mdio_in      (mdio_in),
    .mdio_out     (mdio_out),
    .mdio_enable  (mdio_enable),
    .reg_rd_strobe(reg_rd_strobe),
    .reg_rdata    (reg_rdata),
    .reg_wr_strobe(reg_wr_strobe),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(kind_e k, logic [4:0] a, logic [15:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endfunction

  task automatic observe(kind_e kind, logic [4:0] addr, logic [15:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: addr %0d data %h, nothing expected", kind.name(), addr, data);
      return;
    end
    e = sb.pop_front();
    check({"kind_", kind.name()}, 32'(kind), 32'(e.kind));
    if (kind != EV_RDATA) check({"addr_", kind.name()}, 32'(addr), 32'(e.addr));
    if (kind != EV_RD)    check({"data_", kind.name()}, 32'(data), 32'(e.data));
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (reg_wr_strobe === 1'b1) observe(EV_WR, reg_addr, reg_wdata);
    if (reg_rd_strobe === 1'b1) observe(EV_RD, reg_addr, 16'h0000);
  end

  always @(rdata_ev) observe(EV_RDATA, 5'd0, rdata_obs);

  task automatic send_bit(logic b);
    mdio_in = b;
    repeat (8) @(negedge clk);
    mdc = 1'b1;
    repeat (8) @(negedge clk);
    mdc = 1'b0;
  endtask

  // Master: preamble, then 32 frame bits. Before each rise the pin is sampled as a master would.
  task automatic frame(int pre, logic [1:0] st, logic [1:0] op, logic [4:0] phy, logic [4:0] ra,
                       logic [1:0] ta, logic [15:0] data, bit owned_read, int rst_at);
    logic [31:0] bits;
    logic [15:0] rd;
    bit          driving;
    bits    = {st, op, phy, ra, ta, data};
    driving = owned_read;
    rd      = '0;
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    for (int k = 0; k < 32; k++) begin
      mdio_in = bits[31-k];
      if (owned_read && k == 15) reg_rdata = 16'hDEAD;
      repeat (8) @(negedge clk);
      #1;
      if (k == rst_at) begin
        check("en_before_reset", 32'(mdio_enable), 32'(1));
        reset_n = 1'b0;
        #1;
        check("en_in_reset", 32'(mdio_enable), 32'(0));
        check("out_in_reset", 32'(mdio_out), 32'(1));
        check("addr_in_reset", 32'(reg_addr), 32'(0));
        driving = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
      check($sformatf("en_b%0d", k), 32'(mdio_enable), 32'(driving && k >= 15));
      if (driving && k == 15) check("ta2", 32'(mdio_out), 32'(0));
      if (driving && k >= 16) rd[31-k] = mdio_out;
      mdc = 1'b1;
      repeat (8) @(negedge clk);
      mdc = 1'b0;
    end
    repeat (8) @(negedge clk);
    check("en_after_frame", 32'(mdio_enable), 32'(0));
    if (driving) begin
      rdata_obs = rd;
      ->rdata_ev;
    end
  endtask

  task automatic wr(int pre, logic [4:0] phy, logic [4:0] ra, logic [1:0] ta, logic [15:0] d);
    frame(pre, 2'b01, 2'b01, phy, ra, ta, d, 1'b0, -1);
  endtask

  task automatic rd_frame(int pre, logic [4:0] phy, logic [4:0] ra, int rst_at);
    frame(pre, 2'b01, 2'b10, phy, ra, 2'b11, 16'hFFFF, phy == 5'd1, rst_at);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_en", 32'(mdio_enable), 32'(0));
    check("rst_out", 32'(mdio_out), 32'(1));
    check("rst_rd_strobe", 32'(reg_rd_strobe), 32'(0));
    check("rst_wr_strobe", 32'(reg_wr_strobe), 32'(0));
    check("rst_addr", 32'(reg_addr), 32'(0));
    check("rst_wdata", 32'(reg_wdata), 32'(0));
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // One preamble bit short: ignored, even with suppression (first frame after reset).
    wr(31, 5'd1, 5'd9, 2'b10, 16'h1111);
    expect_ev(EV_WR, 5'd9, 16'h1111);
    wr(32, 5'd1, 5'd9, 2'b10, 16'h1111);

    expect_ev(EV_WR, 5'd5, 16'hA5C3);
    wr(32, 5'd1, 5'd5, 2'b10, 16'hA5C3);

    reg_rdata = 16'h1234;
    expect_ev(EV_RD, 5'd2, 16'h0000);
    expect_ev(EV_RDATA, 5'd0, 16'h1234);
    rd_frame(32, 5'd1, 5'd2, -1);

    // Foreign PHY: skipped, then an addressed read right behind it.
    rd_frame(32, 5'd3, 5'd2, -1);
    reg_rdata = 16'h5A3C;
    expect_ev(EV_RD, 5'd5, 16'h0000);
    expect_ev(EV_RDATA, 5'd0, 16'h5A3C);
    rd_frame(32, 5'd1, 5'd5, -1);

    wr(32, 5'd1, 5'd4, 2'b11, 16'hBEEF);
    frame(32, 2'b00, 2'b01, 5'd1, 5'd7, 2'b10, 16'h0000, 1'b0, -1);
    expect_ev(EV_WR, 5'd6, 16'h0F0F);
    wr(32, 5'd1, 5'd6, 2'b10, 16'h0F0F);

    // Single idle 1 between frames.
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    expect_ev(EV_WR, 5'd8, 16'h7777);
`endif
    wr(1, 5'd1, 5'd8, 2'b10, 16'h7777);

    // Reset in the middle of a read's data phase, then recovery.
    reg_rdata = 16'h1234;
    expect_ev(EV_RD, 5'd2, 16'h0000);
    rd_frame(32, 5'd1, 5'd2, 20);
    expect_ev(EV_WR, 5'd3, 16'h3C3C);
    wr(32, 5'd1, 5'd3, 2'b10, 16'h3C3C);

    repeat (20) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
